// File: rtl/spi_pkg.sv
// Shared types and constants for the clock-synchronous SPI slave.
// Bit counter, byte type and the two-state transfer FSM encoding.
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = 3;

  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [SPI_BITS-1:0] byte_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // True when the counter points at the MSB, i.e. the next rise completes a byte.
  function automatic logic cnt_last(input cnt_t c);
    return c == cnt_t'(SPI_BITS - 1);
  endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Parallel side of the SPI slave: tx byte stream in, rx byte stream out.
interface spi_slave_sync_if;
  import spi_pkg::*;

  byte_t tx_data;
  logic  tx_valid;
  logic  tx_ready;
  byte_t rx_data;
  logic  rx_valid;
  logic  tx_underrun;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output tx_underrun
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  tx_underrun
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input plus registered
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // STAGES must be at least 2 for the chain slice below to be meaningful.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on clk: receives one byte per 8 sck rises and
// returns a byte on miso LSB first, with valid/ready parallel ports.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter byte_t IDLE_TX     = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  spi_slave_sync_if.slave bus
);

  logic       sck_rise;
  logic       sck_fall;
  logic       cs_s;
  logic       cs_rise;
  logic       cs_fall;
  logic       mosi_s;
  logic       sck_level_unused;
  logic [1:0] mosi_edges_unused;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .dout (sck_level_unused),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (cs),
    .dout (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .dout (mosi_s),
    .rise (mosi_edges_unused[0]),
    .fall (mosi_edges_unused[1])
  );

  spi_state_t state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  byte_t      rx_shift_q, rx_shift_d;
  byte_t      tx_shift_q, tx_shift_d;
  byte_t      rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       byte_done_q, byte_done_d;
  logic       load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      byte_done_q <= byte_done_d;
    end
  end

  // byte_done marks "bit 7 received"; the following sck fall reloads instead
  // of shifting. A fall with cnt 0 and no byte_done is the leading fall of a
  // frame, where miso already holds bit 0, so nothing moves.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    byte_done_d = byte_done_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d     = ACTIVE;
          load        = 1'b1;
          cnt_d       = '0;
          byte_done_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_fall) begin
          state_d     = IDLE;
          cnt_d       = '0;
          byte_done_d = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d[cnt_q] = mosi_s;
          cnt_d             = cnt_q + cnt_t'(1);
          if (cnt_last(cnt_q)) begin
            rx_data_d   = rx_shift_d;
            rx_valid_d  = 1'b1;
            byte_done_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (byte_done_q) begin
            load        = 1'b1;
            byte_done_d = 1'b0;
          end else if (cnt_q != '0) begin
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tx_shift_d = bus.tx_valid ? bus.tx_data : IDLE_TX;
    end
  end

  assign bus.tx_ready    = load;
  assign bus.tx_underrun = load & ~bus.tx_valid;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;

  assign miso = (state_q == ACTIVE && cs_s) ? tx_shift_q[0] : 1'bz;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: an SPI master model with sck idle high, a tx
// byte source, and an rx_valid monitor popping a queue of expected bytes.
module tb_spi_slave_sync;
  import spi_pkg::*;

  localparam int HALF = 80;
  localparam int TCLK = 10;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sck  = 1'b1;
  logic cs   = 1'b0;
  logic mosi = 1'b0;
  tri1  miso;

  spi_slave_sync_if bus ();

  spi_slave_sync #(
    .SYNC_STAGES (2),
    .IDLE_TX     (8'h00)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sck  (sck),
    .cs   (cs),
    .mosi (mosi),
    .miso (miso),
    .bus  (bus)
  );

  always #(TCLK/2) clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    ready_cnt = 0;
  int    underrun_cnt = 0;
  byte_t exp_rx_q[$];
  byte_t tx_src_q[$];
  logic  hs_pending = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // miso floats to 1 through the tri1 net whenever the slave releases it.
  task automatic checkHiz(input string name);
    checkOutput(name, 32'(miso), 32'h1);
  endtask

  // One SPI bit per iteration: fall + drive mosi, sample miso just before the rise.
  task automatic applyStimulus(input byte_t mosi_byte, input int nbits, output byte_t got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = mosi_byte[i];
      #HALF;
      got[i] = miso;
      sck = 1'b1;
      #HALF;
    end
  endtask

  task automatic startFrame();
    cs = 1'b1;
    #(12*TCLK);
  endtask

  task automatic endFrame();
    cs = 1'b0;
    #(10*TCLK);
  endtask

  // tx source: presents the queue head, pops once a handshake has been seen.
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (hs_pending) void'(tx_src_q.pop_front());
      bus.tx_valid = (tx_src_q.size() > 0);
      bus.tx_data  = (tx_src_q.size() > 0) ? tx_src_q[0] : 8'h00;
      hs_pending   = bus.tx_ready && bus.tx_valid;
    end
  end

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rx_valid: actual=%0h required=none", bus.rx_data);
      end else begin
        checkOutput("rx_data", 32'(bus.rx_data), 32'(exp_rx_q.pop_front()));
      end
    end
    if (bus.tx_ready)    ready_cnt++;
    if (bus.tx_underrun) underrun_cnt++;
  end

  initial begin
    #(400_000*TCLK);
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_t got;
    byte_t b2b_mosi[3];
    byte_t b2b_tx[3];
    b2b_mosi = '{8'h01, 8'h80, 8'hFF};
    b2b_tx   = '{8'h11, 8'h22, 8'h33};

    #23;
    checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h0);
    checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("reset_tx_ready", 32'(bus.tx_ready), 32'h0);
    checkOutput("reset_tx_underrun", 32'(bus.tx_underrun), 32'h0);
    checkHiz("reset_miso_hiz");
    rst = 1'b0;
    #(10*TCLK);

    $display("[TB] single byte");
    tx_src_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    #(3*TCLK);
    startFrame();
    applyStimulus(8'h3C, 8, got);
    checkOutput("single_miso", 32'(got), 32'hA5);
    endFrame();
    checkOutput("single_tx_ready_count", 32'(ready_cnt), 32'd1);

    $display("[TB] back-to-back");
    foreach (b2b_tx[i]) tx_src_q.push_back(b2b_tx[i]);
    foreach (b2b_mosi[i]) exp_rx_q.push_back(b2b_mosi[i]);
    #(3*TCLK);
    startFrame();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(b2b_mosi[i], 8, got);
      checkOutput("b2b_miso", 32'(got), 32'(b2b_tx[i]));
    end
    endFrame();

    $display("[TB] underrun");
    exp_rx_q.push_back(8'hE7);
    startFrame();
    applyStimulus(8'hE7, 8, got);
    checkOutput("underrun_miso", 32'(got), 32'h00);
    endFrame();
    checkOutput("underrun_count", 32'(underrun_cnt), 32'd1);

    // Abort after 5 bits; miso then sits on bit 4 of 8'h0F, which is 0.
    $display("[TB] abort");
    tx_src_q.push_back(8'h0F);
    #(3*TCLK);
    startFrame();
    applyStimulus(8'hF0, 5, got);
    cs = 1'b0;
    #(4*TCLK);
    checkHiz("abort_miso_hiz");
    checkOutput("abort_rx_data_held", 32'(bus.rx_data), 32'hE7);
    #(10*TCLK);
    tx_src_q.push_back(8'hC6);
    exp_rx_q.push_back(8'h5A);
    #(3*TCLK);
    startFrame();
    applyStimulus(8'h5A, 8, got);
    checkOutput("after_abort_miso", 32'(got), 32'hC6);
    endFrame();

    $display("[TB] reset mid-byte");
    tx_src_q.push_back(8'h99);
    #(3*TCLK);
    startFrame();
    applyStimulus(8'h00, 3, got);
    sck = 1'b0;
    #(2*TCLK);
    rst = 1'b1;
    cs  = 1'b0;
    #1;
    checkOutput("midrst_rx_data", 32'(bus.rx_data), 32'h0);
    checkOutput("midrst_rx_valid", 32'(bus.rx_valid), 32'h0);
    checkOutput("midrst_tx_ready", 32'(bus.tx_ready), 32'h0);
    checkOutput("midrst_tx_underrun", 32'(bus.tx_underrun), 32'h0);
    checkHiz("midrst_miso_hiz");
    #(3*TCLK);
    rst = 1'b0;
    sck = 1'b1;
    #(10*TCLK);
    tx_src_q.push_back(8'h3C);
    exp_rx_q.push_back(8'hC3);
    #(3*TCLK);
    startFrame();
    applyStimulus(8'hC3, 8, got);
    checkOutput("after_reset_miso", 32'(got), 32'h3C);
    endFrame();

    $display("[TB] idle noise");
    for (int i = 0; i < 6; i++) begin
      sck  = 1'b0;
      mosi = ~mosi;
      #HALF;
      sck = 1'b1;
      #HALF;
    end
    checkHiz("noise_miso_hiz");

    for (int k = 0; k < 200 && exp_rx_q.size() > 0; k++) @(negedge clk);
    checkOutput("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    checkOutput("tx_ready_total", 32'(ready_cnt), 32'd9);
    checkOutput("underrun_total", 32'(underrun_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
